// File: rtl/kirby_motion_ctrl.sv
// kirby_motion_ctrl: per-frame walk/jump/gravity motion engine; KIRBY_FLOAT_EN adds the float state
module kirby_motion_ctrl #(
  parameter logic [9:0] X_START    = 10'd210,
  parameter logic [9:0] Y_START    = 10'd240,
  parameter logic [9:0] X_MIN      = 10'd203,
  parameter logic [9:0] X_MAX      = 10'd436,
  parameter logic [9:0] Y_MIN      = 10'd152,
  parameter logic [9:0] Y_MAX      = 10'd327,
  parameter logic [9:0] MOVE_STEP  = 10'd2,
  parameter logic [5:0] JUMP_VEL   = 6'd8,
  parameter logic [5:0] GRAVITY    = 6'd1,
  parameter logic [5:0] MAX_FALL   = 6'd8,
  parameter logic [9:0] FLOAT_STEP = 10'd1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  input  logic       exhale,
  input  logic       freeze,
  output logic [9:0] KirbyX,
  output logic [9:0] KirbyY,
  output logic       facing_left,
  output logic [1:0] motion_state,
  output logic [5:0] vy
);
  typedef enum logic [1:0] {GROUND, RISE, FALL, FLOAT} state_t;
  localparam state_t RST_ST = (Y_START == Y_MAX) ? GROUND : FALL;
  state_t st, st_n;
  logic s1, s2, prev, jump_prev, tick, jump_edge, face_n;
  logic [9:0] x_n, y_n;
  logic [5:0] vy_n;
  logic [6:0] step;
  logic [10:0] x11, y11, x_l, x_r, y_rise, y_raw, y_fall;
  assign tick = s2 & ~prev;
  assign jump_edge = jump & ~jump_prev;
  assign motion_state = st;
  assign x11 = {1'b0, KirbyX};
  assign y11 = {1'b0, KirbyY};
  assign x_l = (x11 < {1'b0, X_MIN} + {1'b0, MOVE_STEP}) ? {1'b0, X_MIN} : x11 - {1'b0, MOVE_STEP};
  assign x_r = (x11 > {1'b0, X_MAX} - {1'b0, MOVE_STEP}) ? {1'b0, X_MAX} : x11 + {1'b0, MOVE_STEP};
  assign y_rise = (y11 < {1'b0, Y_MIN} + {5'd0, vy}) ? {1'b0, Y_MIN} : y11 - {5'd0, vy};
  assign step = ({1'b0, vy} + {1'b0, GRAVITY} > {1'b0, MAX_FALL}) ? {1'b0, MAX_FALL} : {1'b0, vy} + {1'b0, GRAVITY};
  assign y_raw = y11 + {4'd0, step};
  assign y_fall = (y_raw > {1'b0, Y_MAX}) ? {1'b0, Y_MAX} : y_raw;
`ifdef KIRBY_FLOAT_EN
  logic [10:0] y_up, y_dn, y_flt;
  assign y_up = (y11 < {1'b0, Y_MIN} + {1'b0, FLOAT_STEP}) ? {1'b0, Y_MIN} : y11 - {1'b0, FLOAT_STEP};
  assign y_dn = (y11 + {1'b0, FLOAT_STEP} > {1'b0, Y_MAX}) ? {1'b0, Y_MAX} : y11 + {1'b0, FLOAT_STEP};
  assign y_flt = jump ? y_up : y_dn;
`else
  logic unused_float;
  assign unused_float = ^{exhale, FLOAT_STEP};
`endif
  always_comb begin
    x_n = KirbyX;
    y_n = KirbyY;
    vy_n = vy;
    st_n = st;
    face_n = facing_left;
    if (left && !right) begin
      x_n = x_l[9:0];
      face_n = 1'b1;
    end else if (right && !left) begin
      x_n = x_r[9:0];
      face_n = 1'b0;
    end
    case (st)
      GROUND: if (jump_edge) begin
        st_n = RISE;
        vy_n = JUMP_VEL;
      end
      RISE: begin
        y_n = y_rise[9:0];
        st_n = (vy <= GRAVITY || y_rise == {1'b0, Y_MIN}) ? FALL : RISE;
        vy_n = (st_n == FALL) ? 6'd0 : vy - GRAVITY;
      end
      FALL: begin
        y_n = y_fall[9:0];
        st_n = (y_fall == {1'b0, Y_MAX}) ? GROUND : FALL;
        vy_n = (st_n == GROUND) ? 6'd0 : step[5:0];
      end
`ifdef KIRBY_FLOAT_EN
      FLOAT: begin
        y_n = exhale ? KirbyY : y_flt[9:0];
        st_n = exhale ? FALL : (y_flt == {1'b0, Y_MAX}) ? GROUND : FLOAT;
        vy_n = 6'd0;
      end
`endif
      default: ;
    endcase
`ifdef KIRBY_FLOAT_EN
    // airborne jump press starts floating in place; drift begins next tick
    if ((st == RISE || st == FALL) && jump_edge) begin
      y_n = KirbyY;
      vy_n = 6'd0;
      st_n = FLOAT;
    end
`endif
  end
  always_ff @(posedge Clk) begin
    s1 <= frame_clk;
    s2 <= s1;
    prev <= s2;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      KirbyX <= X_START;
      KirbyY <= Y_START;
      facing_left <= 1'b0;
      vy <= 6'd0;
      st <= RST_ST;
      jump_prev <= 1'b0;
    end else if (tick) begin
      jump_prev <= jump;
      if (!freeze) begin
        KirbyX <= x_n;
        KirbyY <= y_n;
        facing_left <= face_n;
        vy <= vy_n;
        st <= st_n;
      end
    end
  end
endmodule

// File: tb/tb_kirby_motion_ctrl.sv
// tb_kirby_motion_ctrl: directed frame ticks checked every cycle against a per-frame behavioural model
module tb_kirby_motion_ctrl;
  logic Clk = 0, Reset = 1, frame_clk = 0, left = 0, right = 0, jump = 0, exhale = 0, freeze = 0;
  logic [9:0] KirbyX, KirbyY;
  logic facing_left;
  logic [1:0] motion_state;
  logic [5:0] vy;
  int cnt = 0, errs = 0;
  bit chk = 0;
  int m_x, m_y, m_vy, m_st, m_f, m_jp;

  kirby_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .left(left), .right(right),
    .jump(jump), .exhale(exhale), .freeze(freeze), .KirbyX(KirbyX), .KirbyY(KirbyY),
    .facing_left(facing_left), .motion_state(motion_state), .vy(vy)
  );

  always #10 Clk = ~Clk;

  task automatic cmp(input string n, input int a, input int e);
    cnt++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 210; m_y = 240; m_vy = 0; m_st = 2; m_f = 0; m_jp = 0;
  endtask

  // one frame of motion, straight from the rules: 0 GROUND, 1 RISE, 2 FALL, 3 FLOAT
  task automatic model_tick();
    int s, ny;
    bit je;
    je = jump && !m_jp;
    m_jp = jump;
    if (freeze) return;
    if (left && !right) begin m_x = (m_x - 2 < 203) ? 203 : m_x - 2; m_f = 1; end
    else if (right && !left) begin m_x = (m_x + 2 > 436) ? 436 : m_x + 2; m_f = 0; end
`ifdef KIRBY_FLOAT_EN
    if (je && (m_st == 1 || m_st == 2)) begin m_st = 3; m_vy = 0; return; end
    if (m_st == 3) begin
      if (exhale) begin m_st = 2; m_vy = 0; end
      else begin
        m_y = jump ? ((m_y - 1 < 152) ? 152 : m_y - 1) : ((m_y + 1 > 327) ? 327 : m_y + 1);
        if (m_y == 327) m_st = 0;
      end
      return;
    end
`endif
    if (m_st == 0) begin
      if (je) begin m_st = 1; m_vy = 8; end
    end else if (m_st == 1) begin
      ny = m_y - m_vy;
      if (ny < 152) ny = 152;
      m_y = ny;
      if (m_vy <= 1 || ny == 152) begin m_st = 2; m_vy = 0; end
      else m_vy = m_vy - 1;
    end else if (m_st == 2) begin
      s = (m_vy + 1 > 8) ? 8 : m_vy + 1;
      m_y = (m_y + s > 327) ? 327 : m_y + s;
      if (m_y == 327) begin m_st = 0; m_vy = 0; end
      else m_vy = s;
    end
  endtask

  always @(negedge Clk) if (chk) begin
    cmp("x", KirbyX, m_x);
    cmp("y", KirbyY, m_y);
    cmp("vy", vy, m_vy);
    cmp("state", motion_state, m_st);
    cmp("facing", facing_left, m_f);
  end

  task automatic tick();
    @(negedge Clk) frame_clk = 1;
    repeat (3) @(posedge Clk);
    model_tick();
    @(negedge Clk) frame_clk = 0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge Clk);
    model_reset();
    @(negedge Clk) Reset = 0;
    chk = 1;
    cmp("lit_reset_x", KirbyX, 210);
    cmp("lit_reset_y", KirbyY, 240);
    cmp("lit_reset_state", motion_state, 2);
    ticks(8);
    cmp("lit_fall_t8_y", KirbyY, 276);
    ticks(6);
    cmp("lit_fall_t14_y", KirbyY, 324);
    cmp("lit_fall_t14_state", motion_state, 2);
    tick();
    cmp("lit_land_y", KirbyY, 327);
    cmp("lit_land_state", motion_state, 0);
    cmp("lit_fall_x", KirbyX, 210);
    jump = 1;
    tick();
    cmp("lit_jump_state", motion_state, 1);
    cmp("lit_jump_vy", vy, 8);
    cmp("lit_jump_y", KirbyY, 327);
    ticks(7);
    cmp("lit_rise_y7", KirbyY, 292);
    cmp("lit_rise_vy1", vy, 1);
    jump = 0;
    tick();
    cmp("lit_apex_y", KirbyY, 291);
    cmp("lit_apex_state", motion_state, 2);
    for (int i = 0; i < 40 && m_st != 0; i++) tick();
    cmp("lit_relanded_y", KirbyY, 327);
    left = 1;
    ticks(3);
    cmp("lit_left_204", KirbyX, 204);
    ticks(2);
    cmp("lit_left_clamp", KirbyX, 203);
    cmp("lit_left_face", facing_left, 1);
    right = 1;
    tick();
    cmp("lit_both_x", KirbyX, 203);
    cmp("lit_both_face", facing_left, 1);
    left = 0;
    ticks(118);
    cmp("lit_right_clamp", KirbyX, 436);
    cmp("lit_right_face", facing_left, 0);
    right = 0;
    jump = 1;
    tick();
    jump = 0;
    tick();
    cmp("lit_pre_freeze_y", KirbyY, 319);
    freeze = 1; left = 1;
    ticks(3);
    cmp("lit_freeze_y", KirbyY, 319);
    cmp("lit_freeze_vy", vy, 7);
    cmp("lit_freeze_x", KirbyX, 436);
    freeze = 0; left = 0;
    tick();
    cmp("lit_resume_y", KirbyY, 312);
    cmp("lit_resume_vy", vy, 6);
    // tick is live in the very cycle Reset is sampled
    @(negedge Clk) frame_clk = 1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1;
    @(posedge Clk);
    model_reset();
    #1 Reset = 0;
    @(negedge Clk) frame_clk = 0;
    repeat (3) @(negedge Clk);
    cmp("lit_rst_tick_y", KirbyY, 240);
    cmp("lit_rst_tick_state", motion_state, 2);
    cmp("lit_rst_tick_vy", vy, 0);
    tick();
    cmp("lit_after_rst_y", KirbyY, 241);
    jump = 1;
    tick();
`ifdef KIRBY_FLOAT_EN
    cmp("lit_float_enter", motion_state, 3);
    cmp("lit_float_y", KirbyY, 241);
    ticks(4);
    cmp("lit_float_up4", KirbyY, 237);
    jump = 0; exhale = 1;
    tick();
    cmp("lit_exhale_state", motion_state, 2);
    cmp("lit_exhale_vy", vy, 0);
    exhale = 0;
`else
    cmp("lit_air_jump_state", motion_state, 2);
    cmp("lit_air_jump_y", KirbyY, 243);
    jump = 0; exhale = 1;
    tick();
    cmp("lit_exhale_ignored", motion_state, 2);
    exhale = 0;
`endif
    ticks(3);
    @(negedge Clk);
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule
